oam_dma_ctrl: RTL and testbench

OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

---
 rtl/oam_dma_ctrl.sv | 118 +++++++++++
 tb/tb_oam_dma_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA engine: a write of a page number to DMA_REG_ADDR stalls
// the CPU and copies that 256-byte page into the PPU OAM data port.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_PORT_ADDR = 16'h2004
) (
  input  logic        sys_clock,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_rd_cycle,
  output logic        cpu_rdy,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_we,
  input  logic [7:0]  bus_rdata,
  output logic        dma_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       par_q;
  logic       trig;

  assign trig = cpu_we && (cpu_addr == DMA_REG_ADDR);

  always_ff @(posedge sys_clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      data_q  <= 8'h00;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      par_q   <= ~par_q;
    end
  end

  // READ must land on an even cycle; an odd HALT exit goes via ALIGN
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (trig) begin
          page_d  = cpu_wdata;
          idx_d   = 8'h00;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (cpu_rd_cycle) begin
          state_d = par_q ? S_READ : S_ALIGN;
        end
      end
      S_ALIGN: begin
        state_d = S_READ;
      end
      S_READ: begin
        data_d  = bus_rdata;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        idx_d   = idx_q + 8'd1;
        state_d = (idx_q == 8'hFF) ? S_IDLE : S_READ;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    cpu_rdy   = (state_q == S_IDLE);
    dma_busy  = (state_q != S_IDLE);
    cpu_rdata = bus_rdata;
    bus_addr  = cpu_addr;
    bus_wdata = cpu_wdata;
    bus_we    = cpu_we;
    if (!reset) begin
      bus_we = 1'b0;
    end else begin
      unique case (state_q)
        S_READ: begin
          bus_addr = {page_q, idx_q};
          bus_we   = 1'b0;
        end
        S_WRITE: begin
          bus_addr  = OAM_PORT_ADDR;
          bus_wdata = data_q;
          bus_we    = 1'b1;
        end
        default: begin
          bus_we = cpu_we;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl with a combinational memory model
// driving bus_rdata from bus_addr.
module tb_oam_dma_ctrl;

  logic        sys_clock;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_rd_cycle;
  logic        cpu_rdy;
  logic [7:0]  cpu_rdata;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_we;
  logic [7:0]  bus_rdata;
  logic        dma_busy;
  logic        par_m;
  int          checks;
  int          errors;

  oam_dma_ctrl dut (
    .sys_clock    (sys_clock),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_we       (cpu_we),
    .cpu_rd_cycle (cpu_rd_cycle),
    .cpu_rdy      (cpu_rdy),
    .cpu_rdata    (cpu_rdata),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_we       (bus_we),
    .bus_rdata    (bus_rdata),
    .dma_busy     (dma_busy)
  );

  function automatic logic [7:0] memf(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  assign bus_rdata = memf(bus_addr);

  initial sys_clock = 1'b0;
  always #5 sys_clock = ~sys_clock;

  // parity of the current cycle, as seen after each rising edge
  initial par_m = 1'b0;
  always @(posedge sys_clock) par_m <= reset ? ~par_m : 1'b0;

  task automatic idle_inputs();
    cpu_we       = 1'b0;
    cpu_addr     = 16'h8000;
    cpu_wdata    = 8'h00;
    cpu_rd_cycle = 1'b1;
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    cpu_we       = 1'b1;
    cpu_addr     = 16'h4014;
    cpu_wdata    = 8'h77;
    cpu_rd_cycle = 1'b0;
    @(posedge sys_clock);
    @(posedge sys_clock);
    @(negedge sys_clock);
    checks++;
    if (cpu_rdy !== 1'b1 || dma_busy !== 1'b0 || bus_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_out rdy=%b busy=%b we=%b required 1 0 0",
               cpu_rdy, dma_busy, bus_we);
    end
    checks++;
    if (bus_addr !== 16'h4014 || bus_wdata !== 8'h77 ||
        cpu_rdata !== memf(16'h4014)) begin
      errors++;
      $display("FAIL reset_pass addr=%h wdata=%h rdata=%h required 4014 77 %h",
               bus_addr, bus_wdata, cpu_rdata, memf(16'h4014));
    end
    @(posedge sys_clock);
    #1;
    reset = 1'b1;
    idle_inputs();
    @(negedge sys_clock);
    checks++;
    if (cpu_rdy !== 1'b1 || dma_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release rdy=%b busy=%b required 1 0",
               cpu_rdy, dma_busy);
    end
  endtask

  task automatic run_dma(input logic [7:0] pg, input logic odd,
                         input int nhw, input int rt_idx,
                         input int exp_stall, input int exp_other,
                         input string nm);
    int stall, nrd, nwr, nother, bad, badpt;
    logic [15:0] last;
    bit rt_go, done;
    stall = 0; nrd = 0; nwr = 0; nother = 0;
    bad = 0; badpt = 0; rt_go = 0; done = 0;
    last = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      @(posedge sys_clock);
      #1;
      if (par_m == odd) break;
    end
    cpu_we       = 1'b1;
    cpu_addr     = 16'h4014;
    cpu_wdata    = pg;
    cpu_rd_cycle = 1'b0;
    @(negedge sys_clock);
    checks++;
    if (bus_we !== 1'b1 || bus_addr !== 16'h4014 ||
        bus_wdata !== pg || cpu_rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s trig we=%b addr=%h wd=%h rdy=%b required 1 4014 %h 1",
               nm, bus_we, bus_addr, bus_wdata, cpu_rdy, pg);
    end
    for (int k = 0; k < 700; k++) begin
      @(posedge sys_clock);
      #1;
      idle_inputs();
      if (k < nhw) begin
        cpu_rd_cycle = 1'b0;
        cpu_we       = 1'b1;
        cpu_addr     = 16'h0300 + k[15:0];
        cpu_wdata    = 8'h90 + k[7:0];
      end
      if (rt_go) begin
        cpu_we    = 1'b1;
        cpu_addr  = 16'h4014;
        cpu_wdata = 8'hC3;
        rt_go     = 0;
      end
      @(negedge sys_clock);
      if (cpu_rdy === 1'b1) begin
        done = 1;
        break;
      end
      stall++;
      if (cpu_rdata !== memf(bus_addr)) bad++;
      if (k < nhw && (bus_we !== 1'b1 || bus_addr !== 16'h0300 + k[15:0] ||
                      bus_wdata !== 8'h90 + k[7:0])) badpt++;
      if (bus_we === 1'b0 && bus_addr[15:8] == pg) begin
        if (bus_addr[7:0] !== nrd[7:0] || nrd != nwr) bad++;
        if (nrd == rt_idx) rt_go = 1;
        last = bus_addr;
        nrd++;
      end else if (bus_we === 1'b1 && bus_addr === 16'h2004) begin
        if (nwr >= nrd || bus_wdata !== memf(last)) bad++;
        nwr++;
      end else begin
        nother++;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout stall=%0d required <700", nm, stall);
    end
    checks++;
    if (stall != exp_stall) begin
      errors++;
      $display("FAIL %s stall got %0d required %0d", nm, stall, exp_stall);
    end
    checks++;
    if (nrd != 256 || nwr != 256) begin
      errors++;
      $display("FAIL %s pairs rd=%0d wr=%0d required 256 256", nm, nrd, nwr);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s order_data bad=%0d required 0", nm, bad);
    end
    checks++;
    if (nother != exp_other) begin
      errors++;
      $display("FAIL %s halt_align got %0d required %0d",
               nm, nother, exp_other);
    end
    if (nhw > 0) begin
      checks++;
      if (badpt != 0) begin
        errors++;
        $display("FAIL %s halt_pass bad=%0d required 0", nm, badpt);
      end
    end
    checks++;
    if (dma_busy !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 16'h8000) begin
      errors++;
      $display("FAIL %s end busy=%b we=%b addr=%h required 0 0 8000",
               nm, dma_busy, bus_we, bus_addr);
    end
  endtask

  task automatic test_align();
    run_dma(8'h02, 1'b1, 0, -1, 514, 2, "align");
  endtask

  task automatic test_no_align();
    run_dma(8'h03, 1'b0, 0, -1, 513, 1, "no_align");
  endtask

  task automatic test_halt_ext();
    run_dma(8'h04, 1'b1, 2, -1, 516, 4, "halt_ext");
  endtask

  task automatic test_retrigger();
    run_dma(8'h05, 1'b0, 0, 10, 513, 1, "retrig");
  endtask

  task automatic test_abort();
    bit found;
    int hits;
    found = 0;
    hits  = 0;
    @(posedge sys_clock);
    #1;
    cpu_we    = 1'b1;
    cpu_addr  = 16'h4014;
    cpu_wdata = 8'h07;
    for (int k = 0; k < 700; k++) begin
      @(posedge sys_clock);
      #1;
      idle_inputs();
      @(negedge sys_clock);
      if (bus_we === 1'b0 && bus_addr === 16'h0764) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL abort_find read of 0764 not seen required seen");
    end
    reset = 1'b0;
    @(posedge sys_clock);
    #1;
    @(negedge sys_clock);
    checks++;
    if (cpu_rdy !== 1'b1 || dma_busy !== 1'b0 || bus_we !== 1'b0) begin
      errors++;
      $display("FAIL abort_state rdy=%b busy=%b we=%b required 1 0 0",
               cpu_rdy, dma_busy, bus_we);
    end
    @(posedge sys_clock);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge sys_clock);
      if (bus_we === 1'b1 && bus_addr === 16'h2004) hits++;
      if (dma_busy !== 1'b0) hits++;
    end
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL abort_quiet dma activity=%0d required 0", hits);
    end
  endtask

  task automatic test_back_to_back();
    run_dma(8'h06, 1'b1, 0, -1, 514, 2, "restart");
    run_dma(8'h01, 1'b0, 0, -1, 513, 1, "b2b");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_align();
    test_no_align();
    test_halt_ext();
    test_retrigger();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
